// File: rtl/regbank_writer_if.sv
// Write-request channel into the register bank: valid/ready handshake
// carrying a 5-bit destination index and a data word.
interface regbank_writer_if #(
  parameter int Width = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [Width-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regbank_writer.sv
// Write side of the 32-entry register bank.
// Accepted writes pass through a single pending stage before committing, so
// the pending address/data are visible for hazard forwarding. Register 0 is
// hardwired to zero. A clear engine zeroes registers 1..31, one per cycle.
//
// state | meaning
// RUN   | normal operation, writes accepted unless clear_req is high
// CLEAR | sweep in progress, clr_idx names the register zeroed at the next edge
module regbank_writer #(
  parameter int Width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regbank_writer_if.slave       wr,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  pend_valid,
  output logic [4:0]            pend_addr,
  output logic [Width-1:0]      pend_data,
  output logic [32*Width-1:0]   q_flat
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic             ready_c;
  logic             busy_c;
  logic             accept;
  logic [Width-1:0] regs [0:31];

  // State register and clear index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      clr_idx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic; the index stops at 31 and returns to 0 with RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = 5'd1;
        end
      end
      CLEAR: begin
        if (clr_idx_q == 5'd31) begin
          state_d   = RUN;
          clr_idx_d = 5'd0;
        end else begin
          clr_idx_d = 5'(clr_idx_q + 5'd1);
        end
      end
      default: begin
        state_d   = RUN;
        clr_idx_d = 5'd0;
      end
    endcase
  end

  // FSM outputs: ready drops combinationally as soon as a clear is requested.
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    unique case (state_q)
      RUN:     ready_c = !clear_req;
      CLEAR:   busy_c  = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign wr.wr_ready = ready_c;
  assign clear_busy  = busy_c;
  assign accept      = wr.wr_valid && ready_c;

  // Pending stage; writes to address 0 complete the handshake but are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= 5'd0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept && (wr.wr_addr != 5'd0);
      if (accept && (wr.wr_addr != 5'd0)) begin
        pend_addr <= wr.wr_addr;
        pend_data <= wr.wr_data;
      end
    end
  end

  // Register array: commit from the pending stage, or zero one entry per
  // CLEAR cycle. A pending write can only coexist with the entry edge, which
  // is still in RUN, so the two never target the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (pend_valid) begin
        regs[pend_addr] <= pend_data;
      end
      if (state_q == CLEAR) begin
        regs[clr_idx_q] <= '0;
      end
      regs[0] <= '0;
    end
  end

  // Flatten the bank for the read selector.
  always_comb begin
    q_flat = '0;
    for (int i = 0; i < 32; i++) begin
      q_flat[i*Width +: Width] = regs[i];
    end
  end

endmodule

// File: tb/tb_regbank_writer.sv
// Directed bench for regbank_writer: write pipeline, address 0, back-to-back
// writes, clear sweep, write/clear collision and reset during a sweep.
module tb_regbank_writer;
  localparam int Width = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                clear_req;
  logic                clear_busy;
  logic                pend_valid;
  logic [4:0]          pend_addr;
  logic [Width-1:0]    pend_data;
  logic [32*Width-1:0] q_flat;

  int n_asserts = 0;
  int n_fail    = 0;

  regbank_writer_if #(.Width(Width)) bus ();

  regbank_writer #(.Width(Width)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (bus),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .q_flat     (q_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Width-1:0] rd(input int k);
    return q_flat[k*Width +: Width];
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    clear_req    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_q_zero", 64'(q_flat == '0), 64'd1);
    chk("rst_pend_valid", 64'(pend_valid), 64'd0);
    chk("rst_pend_addr", 64'(pend_addr), 64'd0);
    chk("rst_pend_data", 64'(pend_data), 64'd0);
    chk("rst_busy", 64'(clear_busy), 64'd0);
    chk("rst_ready", 64'(bus.wr_ready), 64'd1);
    clear_req = 1'b1;
    settle();
    chk("rst_ready_clrreq", 64'(bus.wr_ready), 64'd0);
    clear_req = 1'b0;
    settle();

    // Single write, addr 5
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'hDEADBEEF;
    settle();
    chk("w5_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = '0;
    chk("w5_pend_valid", 64'(pend_valid), 64'd1);
    chk("w5_pend_addr", 64'(pend_addr), 64'd5);
    chk("w5_pend_data", 64'(pend_data), 64'hDEADBEEF);
    chk("w5_not_yet", 64'(rd(5)), 64'd0);
    tick();
    chk("w5_commit", 64'(rd(5)), 64'hDEADBEEF);
    chk("w5_pend_drop", 64'(pend_valid), 64'd0);

    // Address 0 write is accepted and dropped
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'hFFFFFFFF;
    settle();
    chk("w0_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    chk("w0_pend_valid", 64'(pend_valid), 64'd0);
    chk("w0_reg0_a", 64'(rd(0)), 64'd0);
    tick();
    chk("w0_reg0_b", 64'(rd(0)), 64'd0);
    chk("w0_reg5_kept", 64'(rd(5)), 64'hDEADBEEF);

    // Back-to-back writes
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd3;
    bus.wr_data  = 32'd1;
    tick();
    chk("b2b_pend1", 64'(pend_valid), 64'd1);
    bus.wr_data = 32'd2;
    tick();
    chk("b2b_pend2", 64'(pend_valid), 64'd1);
    chk("b2b_reg3_first", 64'(rd(3)), 64'd1);
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'd9;
    tick();
    chk("b2b_pend3", 64'(pend_valid), 64'd1);
    chk("b2b_pend3_addr", 64'(pend_addr), 64'd7);
    chk("b2b_reg3_second", 64'(rd(3)), 64'd2);
    bus.wr_valid = 1'b0;
    tick();
    chk("b2b_pend_drop", 64'(pend_valid), 64'd0);
    chk("b2b_reg3", 64'(rd(3)), 64'd2);
    chk("b2b_reg7", 64'(rd(7)), 64'd9);

    // Fill 1..31 with i, then sweep
    for (int i = 1; i < 32; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(i);
      bus.wr_data  = 32'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    for (int k = 1; k < 32; k++) chk("fill", 64'(rd(k)), 64'(k));
    clear_req = 1'b1;
    settle();
    chk("clr_ready_req", 64'(bus.wr_ready), 64'd0);
    tick();
    clear_req = 1'b0;
    for (int k = 1; k < 32; k++) begin
      chk("clr_busy", 64'(clear_busy), 64'd1);
      chk("clr_ready", 64'(bus.wr_ready), 64'd0);
      chk("clr_before", 64'(rd(k)), 64'(k));
      clear_req = (k == 10);
      tick();
      clear_req = 1'b0;
      chk("clr_after", 64'(rd(k)), 64'd0);
    end
    chk("clr_busy_end", 64'(clear_busy), 64'd0);
    chk("clr_ready_end", 64'(bus.wr_ready), 64'd1);
    chk("clr_all_zero", 64'(q_flat == '0), 64'd1);
    tick();
    chk("clr_no_requeue", 64'(clear_busy), 64'd0);

    // Write pending while clear_req collides with a new write
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd4;
    bus.wr_data  = 32'd8;
    tick();
    bus.wr_addr = 5'd6;
    bus.wr_data = 32'd77;
    clear_req   = 1'b1;
    settle();
    chk("col_ready", 64'(bus.wr_ready), 64'd0);
    tick();
    bus.wr_valid = 1'b0;
    clear_req    = 1'b0;
    chk("col_reg4_commit", 64'(rd(4)), 64'd8);
    chk("col_busy", 64'(clear_busy), 64'd1);
    chk("col_pend_valid", 64'(pend_valid), 64'd0);
    tick();
    tick();
    tick();
    chk("col_reg4_held", 64'(rd(4)), 64'd8);
    tick();
    chk("col_reg4_zeroed", 64'(rd(4)), 64'd0);
    chk("col_reg6_never", 64'(rd(6)), 64'd0);
    for (int c = 0; c < 40 && clear_busy; c++) tick();
    chk("col_sweep_done", 64'(clear_busy), 64'd0);

    // Reset ten cycles into a sweep
    for (int i = 1; i < 32; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(i);
      bus.wr_data  = 32'(32'hA0 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("mid_busy", 64'(clear_busy), 64'd1);
    chk("mid_reg9", 64'(rd(9)), 64'd0);
    chk("mid_reg20", 64'(rd(20)), 64'(32'hA0 + 20));
    chk("mid_reg31", 64'(rd(31)), 64'(32'hA0 + 31));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("mid_rst_zero", 64'(q_flat == '0), 64'd1);
    chk("mid_rst_busy", 64'(clear_busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.wr_ready), 64'd1);
    chk("mid_rst_pend", 64'(pend_valid), 64'd0);

    // Reset discards a pending write
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd9;
    bus.wr_data  = 32'h55;
    tick();
    bus.wr_valid = 1'b0;
    chk("prst_pend", 64'(pend_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("prst_pend_gone", 64'(pend_valid), 64'd0);
    tick();
    chk("prst_reg9", 64'(rd(9)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_writer.md
Name: regbank_writer

Overview:
- Write side of the 32-entry register bank. Accepts write requests with a valid/ready handshake and decodes the 5-bit address into one of 32 registers.
- Commits through a one-stage pending register; register 0 is hardwired to zero.
- Exposes all 32 registers as a flat bus that feeds the 32-to-1 read selector, plus pending-write status for hazard forwarding.
- Contains a sequenced clear engine that zeroes the whole bank, one register per cycle.

Parameters:
- Width, 32, data width of each register and of wr_data.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  write request can be accepted this cycle (combinational).
- wr_addr  input  5  destination register index, 0..31.
- wr_data  input  Width  write data.
- clear_req  input  1  request to zero the entire bank.
- clear_busy  output  1  clear sweep in progress.
- pend_valid  output  1  a write is held in the pending stage.
- pend_addr  output  5  address of the pending write.
- pend_data  output  Width  data of the pending write.
- q_flat  output  32*Width  register contents; register i occupies bits [i*Width +: Width].

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- State after reset:
  - All 32 registers are 0; pend_valid=0, pend_addr=0, pend_data=0.
  - FSM is in RUN; clear_busy=0; clear index is 0.
  - wr_ready=1 unless clear_req=1.
- FSM states:
  - RUN: normal writes.
  - CLEAR: sweep in progress.
- Handshake:
  - wr_ready = (state==RUN) && !clear_req.
  - A write is accepted at an edge where wr_valid && wr_ready.
  - wr_addr and wr_data are not required to be held after acceptance.
- Pipeline for an accepted write at edge N:
  - Edge N: pend_valid<=1, pend_addr<=wr_addr, pend_data<=wr_data.
  - Edge N+1: the register at pend_addr <= pend_data.
  - q_flat shows the new value from edge N+1, i.e. 2 cycles after wr_valid was first presented with wr_ready=1.
  - If no new write is accepted at edge N+1, pend_valid<=0.
- Back-to-back writes: throughput is one write per cycle. The pending stage commits and reloads at the same edge.
- Same address on consecutive writes: commit order is preserved, so the later data is the final value.
- Address 0: the write is accepted (handshake completes) but dropped. pend_valid stays 0 for it; register 0 always reads 0.
- Clear sequence:
  - Entry: clear_req=1 in RUN. At the next edge, state<=CLEAR, clear index<=1, clear_busy<=1.
  - A write still pending commits at that same edge; no write can be accepted in that cycle.
  - In CLEAR, at each edge: register[index]<=0 and index increments.
  - When index==31 that register is zeroed; state<=RUN, clear_busy<=0, index<=0.
  - clear_busy is high for exactly 31 cycles.
  - wr_ready=0 throughout CLEAR.
  - clear_req asserted during CLEAR is ignored; it is not queued.
  - clear_req held high after returning to RUN starts a new sweep.
- Reset mid-operation: reset has priority over everything. A clear sweep is aborted and a pending write is discarded; all registers go to 0 and the FSM goes to RUN.
- Widths: no arithmetic on data. The clear index is 5 bits and must not wrap past 31.

Test Plan:
- Reset, then write addr=5, data=32'hDEADBEEF for one cycle.
  - Required: pend_valid=1 with pend_addr=5 the next cycle.
  - Required: q_flat[5*32+:32]=32'hDEADBEEF one cycle later; pend_valid returns to 0.
- Write addr=0, data=32'hFFFFFFFF.
  - Required: wr_ready=1 and the write is accepted; pend_valid stays 0; register 0 reads 0 forever.
- Back-to-back writes on consecutive cycles: addr=3 data=1, addr=3 data=2, addr=7 data=9.
  - Required: reg3 ends at 2 and reg7 ends at 9.
  - Required: pend_valid stays high for 3 consecutive cycles.
- Fill registers 1..31 with value i, then pulse clear_req for one cycle.
  - Required: clear_busy is high for exactly 31 cycles and wr_ready is 0 during them.
  - Required: register k reads 0 from the k-th CLEAR edge onward; all registers are 0 at the end; wr_ready returns to 1.
- Present wr_valid=1 and clear_req=1 together while write addr=4 data=8 is pending.
  - Required: the new write is not accepted (wr_ready=0).
  - Required: reg4=8 commits, then is zeroed at the 4th CLEAR edge.
- Assert reset 10 cycles into a clear sweep, with registers 20..31 still holding their values.
  - Required: the next cycle shows all registers 0, clear_busy=0, wr_ready=1, pend_valid=0.
